// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse width generator: FSM encoding, default
// width limits and the request range check.
package pulse_pkg;

  localparam int unsigned MIN_W_DEF = 2;
  localparam int unsigned MAX_W_DEF = 6;
  localparam int unsigned GAP_W_DEF = 1;

  // Width of the request field and of the phase counter.
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // A requested width is legal when it lies inside [min_w, max_w].
  function automatic logic width_legal(input logic [CNT_W-1:0] w,
                                       input int unsigned     min_w,
                                       input int unsigned     max_w);
    return (32'(w) >= min_w) && (32'(w) <= max_w);
  endfunction

endpackage

// File: rtl/pulse_width_gen.sv
// Generates high pulses of a requested width, each followed by a fixed low
// gap, with a one-entry slot holding the next request while a pulse runs.
// GAP_W must be at least 1 and MAX_W at most 7 so the 3-bit counter never wraps.
module pulse_width_gen
  import pulse_pkg::*;
#(
  parameter int unsigned MIN_W = MIN_W_DEF,
  parameter int unsigned MAX_W = MAX_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_width,
  output logic       req_ready,
  output logic       pulse_out,
  output logic       done,
  output logic       err_width,
  output logic       busy
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pend_valid;
  logic             w_pend_valid_nxt;
  logic [CNT_W-1:0] r_pend_width;
  logic [CNT_W-1:0] w_pend_width_nxt;

  logic r_pulse;
  logic r_done;
  logic r_err;
  logic r_busy;
  logic r_req_ready;
  logic w_pulse_nxt;
  logic w_done_nxt;
  logic w_err_nxt;
  logic w_busy_nxt;
  logic w_req_ready_nxt;

  logic             w_accept;
  logic             w_legal;
  logic             w_take;
  logic             w_reject;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_req_load;
  logic [CNT_W-1:0] w_pend_load;

  // Request handshake and range classification.
  always_comb begin
    w_accept    = req_valid & r_req_ready;
    w_legal     = width_legal(req_width, MIN_W, MAX_W);
    w_take      = w_accept & w_legal;
    w_reject    = w_accept & ~w_legal;
    w_cnt_zero  = (r_cnt == '0);
    w_req_load  = req_width - CNT_W'(1);
    w_pend_load = r_pend_width - CNT_W'(1);
  end

  // Next-state, counter and pending-slot logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_width_nxt = r_pend_width;
    case (r_state)
      ST_IDLE: begin
        // Accepted legal widths start straight away, never via the slot.
        if (w_take) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = w_req_load;
        end
      end
      ST_HIGH: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
        if (w_take) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_width_nxt = req_width;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          if (r_pend_valid) begin
            w_state_nxt      = ST_HIGH;
            w_cnt_nxt        = w_pend_load;
            w_pend_valid_nxt = 1'b0;
          end else if (w_take) begin
            // Request on the last gap cycle: same timing as a drained slot.
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = w_req_load;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (w_take) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_width_nxt = req_width;
          end
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_cnt_nxt        = '0;
        w_pend_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output values derived from the upcoming state so every output is a flop.
  always_comb begin
    w_pulse_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_busy_nxt      = 1'b0;
    w_req_ready_nxt = 1'b1;
    w_pulse_nxt     = (w_state_nxt == ST_HIGH);
    w_done_nxt      = (r_state == ST_HIGH) && w_cnt_zero;
    w_err_nxt       = w_reject;
    w_busy_nxt      = (w_state_nxt != ST_IDLE) || w_pend_valid_nxt;
    w_req_ready_nxt = ~w_pend_valid_nxt;
  end

  // FSM state, counter and pending slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_width <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_width <= w_pend_width_nxt;
    end
  end

  // Registered outputs; reset drops any pulse in flight without strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulse     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      r_pulse     <= w_pulse_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= w_busy_nxt;
      r_req_ready <= w_req_ready_nxt;
    end
  end

  assign pulse_out = r_pulse;
  assign done      = r_done;
  assign err_width = r_err;
  assign busy      = r_busy;
  assign req_ready = r_req_ready;

endmodule

// File: tb/tb_pulse_width_gen.sv
// Bench for pulse_width_gen: an edge-indexed schedule model checked every
// cycle, literal checks of the directed scenarios, and a high-run monitor.
module tb_pulse_width_gen;

  localparam int MIN_W = 2;
  localparam int MAX_W = 6;
  localparam int GAP_W = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_width = 3'd0;
  logic       req_ready;
  logic       pulse_out;
  logic       done;
  logic       err_width;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: every accepted legal pulse as (start edge, width).
  int   p_start[$];
  int   p_width[$];
  int   free_edge = 0;
  logic m_ready   = 1'b1;
  int   n_acc_legal = 0;
  int   exp_w[$];
  logic e_pulse, e_done, e_err, e_busy, e_ready;

  // High/low run monitor on the DUT output.
  int   run_hi = 0;
  int   run_lo = 0;
  logic seen_pulse = 1'b0;
  logic prev_pulse = 1'b0;

  pulse_width_gen #(.MIN_W(MIN_W), .MAX_W(MAX_W), .GAP_W(GAP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_width (req_width),
    .req_ready (req_ready),
    .pulse_out (pulse_out),
    .done      (done),
    .err_width (err_width),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d..%0d", name, cyc, act, lo, hi);
    end
  endtask

  // Model update at each edge, then compare DUT outputs 1 time unit later.
  initial begin
    int   k;
    int   s;
    int   w;
    logic rst_s;
    forever begin
      @(posedge clk);
      k     = cyc;
      rst_s = rst;
      e_err = 1'b0;
      if (rst_s) begin
        p_start.delete();
        p_width.delete();
        exp_w.delete();
        free_edge = 0;
      end else if (req_valid && m_ready) begin
        w = int'(req_width);
        if (w >= MIN_W && w <= MAX_W) begin
          s = (k >= free_edge) ? k : free_edge;
          p_start.push_back(s);
          p_width.push_back(w);
          exp_w.push_back(w);
          free_edge = s + w + GAP_W;
          n_acc_legal++;
        end else begin
          e_err = 1'b1;
        end
      end
      e_pulse = 1'b0;
      e_done  = 1'b0;
      e_ready = 1'b1;
      foreach (p_start[i]) begin
        if (k >= p_start[i] && k < p_start[i] + p_width[i]) e_pulse = 1'b1;
        if (k == p_start[i] + p_width[i]) e_done = 1'b1;
        if (p_start[i] > k) e_ready = 1'b0;
      end
      e_busy  = (k < free_edge);
      m_ready = e_ready;
      #1;
      chk("pulse_out", pulse_out, e_pulse);
      chk("done",      done,      e_done);
      chk("err_width", err_width, e_err);
      chk("busy",      busy,      e_busy);
      chk("req_ready", req_ready, e_ready);
      if (rst_s) begin
        run_hi     = 0;
        run_lo     = 0;
        seen_pulse = 1'b0;
        prev_pulse = 1'b0;
      end else begin
        if (pulse_out) begin
          if (!prev_pulse && seen_pulse) chk_rng("gap_len", run_lo, GAP_W, 1000);
          run_hi++;
          run_lo = 0;
        end else begin
          if (prev_pulse) begin
            chk_rng("high_len", run_hi, MIN_W, MAX_W);
            if (exp_w.size() == 0) begin
              chk_int("high_order", run_hi, -1);
            end else begin
              chk_int("high_order", run_hi, exp_w.pop_front());
            end
            seen_pulse = 1'b1;
            run_hi     = 0;
          end
          run_lo++;
        end
        prev_pulse = pulse_out;
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  // Directed scenarios with literal expectations, then random legal traffic.
  initial begin
    logic [10:0] pat_6_3;
    logic [10:0] rdy_6_3;
    int          target;
    int          budget;
    pat_6_3 = 11'b01110111111;
    rdy_6_3 = 11'b11110000001;

    repeat (3) @(negedge clk);
    chk("rst_pulse", pulse_out, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_done",  done,      1'b0);
    rst = 1'b0;
    @(negedge clk);

    // W=2 from idle.
    req_valid = 1'b1; req_width = 3'd2;
    @(negedge clk); req_valid = 1'b0;
    chk("w2_hi0", pulse_out, 1'b1); chk("w2_rdy0", req_ready, 1'b1);
    @(negedge clk);
    chk("w2_hi1", pulse_out, 1'b1); chk("w2_done1", done, 1'b0);
    @(negedge clk);
    chk("w2_lo", pulse_out, 1'b0); chk("w2_done", done, 1'b1); chk("w2_busy", busy, 1'b1);
    @(negedge clk);
    chk("w2_done_end", done, 1'b0); chk("w2_idle", busy, 1'b0); chk("w2_rdy", req_ready, 1'b1);

    // W=6 then W=3 offered during the high phase.
    req_valid = 1'b1; req_width = 3'd6;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 0) req_width = 3'd3;
      if (i == 1) req_valid = 1'b0;
      chk("w63_pulse", pulse_out, pat_6_3[i]);
      chk("w63_ready", req_ready, rdy_6_3[i]);
      if (i == 6) chk("w63_done", done, 1'b1);
    end
    repeat (2) @(negedge clk);

    // Out-of-range widths 1, 7, 0.
    req_valid = 1'b1; req_width = 3'd1;
    @(negedge clk); req_width = 3'd7;
    chk("err_w1", err_width, 1'b1); chk("err_busy1", busy, 1'b0); chk("err_pulse1", pulse_out, 1'b0);
    @(negedge clk); req_width = 3'd0;
    chk("err_w7", err_width, 1'b1); chk("err_busy7", busy, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    chk("err_w0", err_width, 1'b1); chk("err_busy0", busy, 1'b0);
    @(negedge clk);
    chk("err_clear", err_width, 1'b0); chk("err_nopulse", pulse_out, 1'b0);

    // Reset during the 4th high cycle of W=5 with W=2 pending.
    req_valid = 1'b1; req_width = 3'd5;
    @(negedge clk); req_width = 3'd2;
    @(negedge clk); req_valid = 1'b0;
    chk("rst5_pend_rdy", req_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst5_hi4", pulse_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst5_drop", pulse_out, 1'b0); chk("rst5_nodone", done, 1'b0);
    chk("rst5_rdy", req_ready, 1'b1);  chk("rst5_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst5_quiet_pulse", pulse_out, 1'b0);
      chk("rst5_quiet_done",  done,      1'b0);
    end

    // Random legal requests with random valid.
    target = n_acc_legal + 20;
    budget = 2000;
    while (n_acc_legal < target && budget > 0) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_width = 3'($urandom_range(MIN_W, MAX_W));
      budget--;
    end
    req_valid = 1'b0;
    chk("rand_budget", budget > 0, 1'b1);
    repeat (20) @(negedge clk);
    chk_int("rand_all_seen", exp_w.size(), 0);
    chk("rand_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
